// File: rtl/console_io_ctrl_pkg.sv
// Shared types and constants for the console I/O controller: FSM state
// encodings, default sizing and STATUS bit positions.
package console_pkg;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_DATA_W     = 8;

  localparam int ST_IN_AVAIL = 0;
  localparam int ST_OUT_BUSY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_OUT_OVF  = 3;

  function automatic logic [3:0] pack_status(input logic out_ovf, input logic rx_full,
                                             input logic out_busy, input logic in_avail);
    logic [3:0] st;
    st              = 4'b0000;
    st[ST_OUT_OVF]  = out_ovf;
    st[ST_RX_FULL]  = rx_full;
    st[ST_OUT_BUSY] = out_busy;
    st[ST_IN_AVAIL] = in_avail;
    return st;
  endfunction

endpackage

// File: rtl/console_io_ctrl_if.sv
// Console bundle: UART-side 4-phase RX handshake, TX valid/ready, and the
// processor-side strobes and status.
interface console_io_ctrl_if
  import console_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [DATA_W-1:0] CONSOLE_IN;
  logic              CONSOLE_IN_valid;
  logic              CONSOLE_IN_ack;
  logic [DATA_W-1:0] CONSOLE_OUT;
  logic              CONSOLE_OUT_valid;
  logic              CONSOLE_OUT_ready;
  logic              RD_IN;
  logic              WR_OUT;
  logic [DATA_W-1:0] WD;
  logic [DATA_W-1:0] IN_DATA;
  logic [3:0]        STATUS;

  modport slave (
    input  CONSOLE_IN, CONSOLE_IN_valid, CONSOLE_OUT_ready, RD_IN, WR_OUT, WD,
    output CONSOLE_IN_ack, CONSOLE_OUT, CONSOLE_OUT_valid, IN_DATA, STATUS
  );

  modport master (
    output CONSOLE_IN, CONSOLE_IN_valid, CONSOLE_OUT_ready, RD_IN, WR_OUT, WD,
    input  CONSOLE_IN_ack, CONSOLE_OUT, CONSOLE_OUT_valid, IN_DATA, STATUS
  );

endinterface

// File: rtl/console_io_ctrl_fifo.sv
// RX byte buffer: power-of-two circular FIFO with a first-word-fall-through
// head and synchronous reset that also clears storage.
module console_fifo
  import console_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int W     = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == {CNT_W{1'b0}});
  assign full      = (count_r == CNT_W'(DEPTH));
  assign do_pop_s  = pop && !empty;
  // A full buffer only takes a byte when the head leaves on the same edge.
  assign do_push_s = push && (!full || do_pop_s);
  assign head      = mem_r[rd_ptr_r];

  // Storage, wrapping pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/console_io_ctrl.sv
// Console I/O controller: 4-phase RX handshake into a byte FIFO for the
// processor, and a single-entry TX holding register with overflow flag.
module console_io_ctrl
  import console_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic               CLK,
  input  logic               RESET,
  console_io_ctrl_if.slave   bus
);

  rx_state_e         rx_state_r;
  rx_state_e         rx_state_nxt_s;
  tx_state_e         tx_state_r;
  tx_state_e         tx_state_nxt_s;
  logic              rx_push_s;
  logic              rx_ack_s;
  logic              tx_valid_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [DATA_W-1:0] fifo_head_s;
  logic [DATA_W-1:0] out_data_r;
  logic              ovf_r;

  console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_rx_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (rx_push_s),
    .pop   (bus.RD_IN),
    .din   (bus.CONSOLE_IN),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .head  (fifo_head_s)
  );

  // RX state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_state_r <= RX_IDLE;
    end else begin
      rx_state_r <= rx_state_nxt_s;
    end
  end

  // RX next state; the push fires only on the IDLE->ACK transition.
  always_comb begin
    rx_state_nxt_s = rx_state_r;
    rx_push_s      = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (bus.CONSOLE_IN_valid && (!fifo_full_s || bus.RD_IN)) begin
          rx_state_nxt_s = RX_ACK;
          rx_push_s      = 1'b1;
        end else begin
          rx_state_nxt_s = RX_IDLE;
        end
      end
      RX_ACK: begin
        if (!bus.CONSOLE_IN_valid) begin
          rx_state_nxt_s = RX_IDLE;
        end else begin
          rx_state_nxt_s = RX_ACK;
        end
      end
      default: rx_state_nxt_s = RX_IDLE;
    endcase
  end

  // RX outputs.
  always_comb begin
    case (rx_state_r)
      RX_ACK:  rx_ack_s = 1'b1;
      default: rx_ack_s = 1'b0;
    endcase
  end

  // TX state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_state_r <= TX_IDLE;
    end else begin
      tx_state_r <= tx_state_nxt_s;
    end
  end

  // TX next state.
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    case (tx_state_r)
      TX_IDLE: begin
        if (bus.WR_OUT) begin
          tx_state_nxt_s = TX_SEND;
        end else begin
          tx_state_nxt_s = TX_IDLE;
        end
      end
      TX_SEND: begin
        if (bus.CONSOLE_OUT_ready) begin
          tx_state_nxt_s = TX_IDLE;
        end else begin
          tx_state_nxt_s = TX_SEND;
        end
      end
      default: tx_state_nxt_s = TX_IDLE;
    endcase
  end

  // TX outputs.
  always_comb begin
    case (tx_state_r)
      TX_SEND: tx_valid_s = 1'b1;
      default: tx_valid_s = 1'b0;
    endcase
  end

  // TX holding register and sticky overflow; writes while sending are lost.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_data_r <= {DATA_W{1'b0}};
      ovf_r      <= 1'b0;
    end else begin
      if (tx_state_r == TX_IDLE && bus.WR_OUT) begin
        out_data_r <= bus.WD;
      end
      if (tx_state_r == TX_SEND && bus.WR_OUT) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign bus.CONSOLE_IN_ack    = rx_ack_s;
  assign bus.CONSOLE_OUT       = out_data_r;
  assign bus.CONSOLE_OUT_valid = tx_valid_s;
  assign bus.IN_DATA           = fifo_head_s;
  assign bus.STATUS            = pack_status(ovf_r, fifo_full_s, tx_valid_s, !fifo_empty_s);

endmodule

// File: tb/tb_console_io_ctrl.sv
// Directed self-checking bench for console_io_ctrl: RX handshake and FIFO,
// backpressure, wrap-around, TX send/overflow, and mid-transfer reset.
module tb_console_io_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  console_io_ctrl_if #(.DATA_W(8)) bus ();

  console_io_ctrl #(
    .FIFO_DEPTH (4),
    .DATA_W     (8)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_send(input logic [7:0] b);
    bus.CONSOLE_IN       = b;
    bus.CONSOLE_IN_valid = 1'b1;
    tick();
    for (int k = 0; k < 20 && bus.CONSOLE_IN_ack !== 1'b1; k++) tick();
    chk("rx_ack_rise", 32'(bus.CONSOLE_IN_ack), 32'h1);
    bus.CONSOLE_IN_valid = 1'b0;
    tick();
    for (int k = 0; k < 20 && bus.CONSOLE_IN_ack !== 1'b0; k++) tick();
    chk("rx_ack_fall", 32'(bus.CONSOLE_IN_ack), 32'h0);
  endtask

  task automatic pop();
    bus.RD_IN = 1'b1;
    tick();
    bus.RD_IN = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_heads [4];
    exp_heads[0] = 8'h41;
    exp_heads[1] = 8'h0D;
    exp_heads[2] = 8'h31;
    exp_heads[3] = 8'h32;

    bus.CONSOLE_IN        = 8'h00;
    bus.CONSOLE_IN_valid  = 1'b0;
    bus.CONSOLE_OUT_ready = 1'b0;
    bus.RD_IN             = 1'b0;
    bus.WR_OUT            = 1'b0;
    bus.WD                = 8'h00;

    // Reset state
    rst = 1'b1;
    tick(2);
    chk("rst_ack", 32'(bus.CONSOLE_IN_ack), 32'h0);
    chk("rst_out_valid", 32'(bus.CONSOLE_OUT_valid), 32'h0);
    chk("rst_out", 32'(bus.CONSOLE_OUT), 32'h0);
    chk("rst_in_data", 32'(bus.IN_DATA), 32'h0);
    chk("rst_status", 32'(bus.STATUS), 32'h0);
    rst = 1'b0;

    // Single 4-phase handshake, byte visible one cycle after sampling edge
    bus.CONSOLE_IN       = 8'h50;
    bus.CONSOLE_IN_valid = 1'b1;
    tick();
    chk("hs_ack", 32'(bus.CONSOLE_IN_ack), 32'h1);
    chk("hs_in_data", 32'(bus.IN_DATA), 32'h50);
    chk("hs_status", 32'(bus.STATUS), 32'h1);
    bus.CONSOLE_IN_valid = 1'b0;
    tick();
    chk("hs_ack_low", 32'(bus.CONSOLE_IN_ack), 32'h0);
    chk("hs_in_data_hold", 32'(bus.IN_DATA), 32'h50);
    pop();
    chk("hs_popped", 32'(bus.STATUS), 32'h0);

    // Long valid: exactly one push
    bus.CONSOLE_IN       = 8'h41;
    bus.CONSOLE_IN_valid = 1'b1;
    tick(10);
    chk("long_ack", 32'(bus.CONSOLE_IN_ack), 32'h1);
    bus.CONSOLE_IN_valid = 1'b0;
    tick();
    chk("long_ack_low", 32'(bus.CONSOLE_IN_ack), 32'h0);
    chk("long_head", 32'(bus.IN_DATA), 32'h41);
    pop();
    chk("long_one_entry", 32'(bus.STATUS), 32'h0);

    // Fill the FIFO, then backpressure the fifth byte
    rx_send(8'h50);
    rx_send(8'h41);
    rx_send(8'h0D);
    rx_send(8'h31);
    chk("fill_status", 32'(bus.STATUS), 32'h5);
    bus.CONSOLE_IN       = 8'h32;
    bus.CONSOLE_IN_valid = 1'b1;
    tick(3);
    chk("bp_ack", 32'(bus.CONSOLE_IN_ack), 32'h0);
    chk("bp_head", 32'(bus.IN_DATA), 32'h50);
    bus.RD_IN = 1'b1;
    tick();
    bus.RD_IN = 1'b0;
    chk("bp_release_ack", 32'(bus.CONSOLE_IN_ack), 32'h1);
    chk("bp_release_head", 32'(bus.IN_DATA), 32'h41);
    chk("bp_release_status", 32'(bus.STATUS), 32'h5);
    bus.CONSOLE_IN_valid = 1'b0;
    tick();
    chk("bp_ack_low", 32'(bus.CONSOLE_IN_ack), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", 32'(bus.IN_DATA), 32'(exp_heads[i]));
      pop();
    end
    chk("drain_empty", 32'(bus.STATUS), 32'h0);

    // Pop on empty is ignored
    pop();
    chk("empty_pop_status", 32'(bus.STATUS), 32'h0);

    // Simultaneous push/pop at occupancy 1, nine round trips
    rx_send(8'h10);
    chk("rt_seed", 32'(bus.IN_DATA), 32'h10);
    for (int i = 0; i < 9; i++) begin
      bus.CONSOLE_IN       = 8'(8'h20 + i);
      bus.CONSOLE_IN_valid = 1'b1;
      bus.RD_IN            = 1'b1;
      tick();
      bus.RD_IN = 1'b0;
      chk("rt_ack", 32'(bus.CONSOLE_IN_ack), 32'h1);
      chk("rt_head", 32'(bus.IN_DATA), 32'(8'h20 + i));
      chk("rt_status", 32'(bus.STATUS), 32'h1);
      bus.CONSOLE_IN_valid = 1'b0;
      tick();
      chk("rt_ack_low", 32'(bus.CONSOLE_IN_ack), 32'h0);
    end
    pop();
    chk("rt_empty", 32'(bus.STATUS), 32'h0);

    // TX: ready low three cycles, overflow write mid-send
    bus.WD     = 8'h57;
    bus.WR_OUT = 1'b1;
    tick();
    bus.WR_OUT = 1'b0;
    chk("tx_c1_valid", 32'(bus.CONSOLE_OUT_valid), 32'h1);
    chk("tx_c1_out", 32'(bus.CONSOLE_OUT), 32'h57);
    chk("tx_c1_status", 32'(bus.STATUS), 32'h2);
    tick();
    chk("tx_c2_valid", 32'(bus.CONSOLE_OUT_valid), 32'h1);
    bus.WD     = 8'h99;
    bus.WR_OUT = 1'b1;
    tick();
    bus.WR_OUT = 1'b0;
    chk("tx_c3_valid", 32'(bus.CONSOLE_OUT_valid), 32'h1);
    chk("tx_c3_out", 32'(bus.CONSOLE_OUT), 32'h57);
    chk("tx_c3_ovf", 32'(bus.STATUS), 32'hA);
    tick();
    chk("tx_c4_valid", 32'(bus.CONSOLE_OUT_valid), 32'h1);
    chk("tx_c4_out", 32'(bus.CONSOLE_OUT), 32'h57);
    bus.CONSOLE_OUT_ready = 1'b1;
    tick();
    chk("tx_done_valid", 32'(bus.CONSOLE_OUT_valid), 32'h0);
    chk("tx_done_status", 32'(bus.STATUS), 32'h8);
    tick(2);
    chk("tx_no_resend", 32'(bus.CONSOLE_OUT_valid), 32'h0);
    bus.CONSOLE_OUT_ready = 1'b0;

    // Concurrent RX and TX, then reset in the middle of both
    bus.CONSOLE_IN       = 8'h5A;
    bus.CONSOLE_IN_valid = 1'b1;
    bus.WD               = 8'h33;
    bus.WR_OUT           = 1'b1;
    tick();
    bus.WR_OUT = 1'b0;
    chk("both_ack", 32'(bus.CONSOLE_IN_ack), 32'h1);
    chk("both_out", 32'(bus.CONSOLE_OUT), 32'h33);
    chk("both_status", 32'(bus.STATUS), 32'hB);
    rst = 1'b1;
    bus.RD_IN = 1'b1;
    tick();
    bus.RD_IN = 1'b0;
    rst = 1'b0;
    chk("mrst_ack", 32'(bus.CONSOLE_IN_ack), 32'h0);
    chk("mrst_out_valid", 32'(bus.CONSOLE_OUT_valid), 32'h0);
    chk("mrst_out", 32'(bus.CONSOLE_OUT), 32'h0);
    chk("mrst_in_data", 32'(bus.IN_DATA), 32'h0);
    chk("mrst_status", 32'(bus.STATUS), 32'h0);
    tick();
    chk("post_rst_ack", 32'(bus.CONSOLE_IN_ack), 32'h1);
    chk("post_rst_head", 32'(bus.IN_DATA), 32'h5A);
    tick(3);
    bus.CONSOLE_IN_valid = 1'b0;
    tick();
    chk("post_rst_ack_low", 32'(bus.CONSOLE_IN_ack), 32'h0);
    chk("post_rst_status", 32'(bus.STATUS), 32'h1);
    pop();
    chk("post_rst_one_push", 32'(bus.STATUS), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
